// File: rtl/dicke_switch_scheduler.sv
// Dicke switch sequencer: switch drive, settle blanking, demod reference and slotted ADC launches tagged with switch phase.
// All outputs registered (one cycle); no backpressure: a slot that finds the ADC busy is dropped and flagged sticky in overrun.
module dicke_switch_scheduler #(
   parameter int unsigned HALF_PERIOD = 50000,
   parameter int unsigned SETTLE      = 5000,
   parameter int unsigned SAMPLES     = 8,
   parameter int unsigned SPACING     = 1000,
   parameter int unsigned CW          = 20
) (
   input  logic clk,
   input  logic clr,
   input  logic enable,
   input  logic adc_done,
   output logic adc_start,
   output logic switch_pwm,
   output logic demod,
   output logic blank,
   output logic sample_valid,
   output logic sample_phase,
   output logic frame_done,
   output logic overrun
);
   localparam int unsigned KW  = $clog2(SAMPLES + 1);
   localparam int unsigned CW1 = CW + 1;
   localparam logic [CW-1:0] T_LAST   = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] T_SETTLE = CW'(SETTLE);
   localparam logic [CW:0]   SPACE_W  = CW1'(SPACING);
   localparam logic [CW:0]   HP_W     = CW1'(HALF_PERIOD);
   localparam logic [KW-1:0] K_LAST   = KW'(SAMPLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;

   state_t        state;
   logic [CW-1:0] t;
   logic [CW-1:0] next_launch;
   logic [KW-1:0] k;
   logic          busy;
   logic          launch_phase;

   logic          boundary;
   logic          launch_slot;
   logic [CW-1:0] t_nxt;
   logic [CW:0]   nl_sum;

   // Decisions look at the timer value of the coming cycle so registered outputs line up with t.
   assign boundary    = (state != ST_IDLE) && (t == T_LAST);
   assign t_nxt       = boundary ? '0 : t + 1'b1;
   assign launch_slot = ((state == ST_SETTLE) || (state == ST_SAMPLE)) && !boundary && (t_nxt == next_launch);
   assign nl_sum      = {1'b0, next_launch} + SPACE_W;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state        <= ST_IDLE;
         t            <= '0;
         next_launch  <= T_SETTLE;
         k            <= '0;
         busy         <= 1'b0;
         launch_phase <= 1'b0;
         adc_start    <= 1'b0;
         switch_pwm   <= 1'b0;
         demod        <= 1'b0;
         blank        <= 1'b1;
         sample_valid <= 1'b0;
         sample_phase <= 1'b0;
         frame_done   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         adc_start    <= 1'b0;
         sample_valid <= 1'b0;
         frame_done   <= 1'b0;

         if (adc_done && busy) begin
            sample_valid <= 1'b1;
            sample_phase <= launch_phase;
            busy         <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state       <= ST_SETTLE;
                  t           <= '0;
                  k           <= '0;
                  next_launch <= T_SETTLE;
               end
            end
            default: begin
               t     <= t_nxt;
               blank <= (t_nxt < T_SETTLE);
               if (t_nxt == T_SETTLE)
                  demod <= boundary ? ~switch_pwm : switch_pwm;

               if (boundary) begin
                  k           <= '0;
                  next_launch <= T_SETTLE;
                  state       <= ST_SETTLE;
                  // A conversion still outstanding at the edge belongs to the old phase: drop it.
                  if (busy && !adc_done) begin
                     busy    <= 1'b0;
                     overrun <= 1'b1;
                  end
                  if (switch_pwm)
                     frame_done <= 1'b1;
                  if (switch_pwm && !enable) begin
                     state      <= ST_IDLE;
                     switch_pwm <= 1'b0;
                     demod      <= 1'b0;
                     blank      <= 1'b1;
                  end else begin
                     switch_pwm <= ~switch_pwm;
                  end
               end else begin
                  if ((state == ST_SETTLE) && (t_nxt == T_SETTLE))
                     state <= ST_SAMPLE;
                  if (launch_slot) begin
                     if (busy) begin
                        overrun <= 1'b1;
                     end else begin
                        adc_start    <= 1'b1;
                        busy         <= 1'b1;
                        launch_phase <= switch_pwm;
                     end
                     k           <= k + 1'b1;
                     next_launch <= nl_sum[CW-1:0];
                     // Remaining slots past the phase end are skipped without flagging.
                     if ((k == K_LAST) || (nl_sum >= HP_W))
                        state <= ST_HOLD;
                  end
               end
            end
         endcase
      end
   end
endmodule
